// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: one pending-write counter per architectural register,
// stalling decode on RAW hazards and counter saturation.
module reg_scoreboard #(
   parameter int NREG     = 32,
   parameter int CNT_W    = 2,
   parameter int BYPASS_W = 1
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            IssueValidD,
   input  logic            FlushD,
   input  logic [4:0]      Rs1D,
   input  logic [4:0]      Rs2D,
   input  logic [4:0]      RdD,
   input  logic            Rs1UsedD,
   input  logic            Rs2UsedD,
   input  logic            RegWriteD,
   input  logic            FlushE,
   input  logic            RetireValidW,
   input  logic [4:0]      RdW,
   output logic            StallD,
   output logic            IssueD,
   output logic [NREG-1:0] BusyMask,
   output logic            SbErr
);

   localparam int              SW      = CNT_W + 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt      [NREG];
   logic [CNT_W-1:0] cnt_next [NREG];
   logic [NREG-1:0]  busy_next;
   logic [NREG-1:0]  underflow;
   logic [4:0]       last_rd;
   logic             last_valid;
   logic             hazard;
   logic             active;
   logic             tracked_issue;

   // A register whose last pending write retires this cycle reads the write-through value.
   function automatic logic ready(input logic [4:0] r, input logic [CNT_W-1:0] c,
                                  input logic ret_valid, input logic [4:0] ret_rd);
      ready = (r == 5'd0) || (c == '0) ||
              ((BYPASS_W == 1) && (c == CNT_W'(1)) && ret_valid && (ret_rd == r));
   endfunction

   always_comb begin
      hazard = (Rs1UsedD && !ready(Rs1D, cnt[Rs1D], RetireValidW, RdW)) ||
               (Rs2UsedD && !ready(Rs2D, cnt[Rs2D], RetireValidW, RdW)) ||
               (RegWriteD && (RdD != 5'd0) && (cnt[RdD] == CNT_MAX));
   end

   assign active        = RST_N && IssueValidD && !FlushD;
   assign StallD        = active && hazard;
   assign IssueD        = active && !hazard;
   assign tracked_issue = IssueD && RegWriteD && (RdD != 5'd0);

   // All increments and decrements are summed in a widened value; a set MSB means underflow.
   always_comb begin
      logic [SW-1:0] sum;
      logic          inc;
      logic          dec_w;
      logic          dec_f;
      sum       = '0;
      inc       = 1'b0;
      dec_w     = 1'b0;
      dec_f     = 1'b0;
      busy_next = '0;
      underflow = '0;
      cnt_next[0] = '0;
      for (int i = 1; i < NREG; i++) begin
         inc   = tracked_issue && (RdD == 5'(i));
         dec_w = RetireValidW && (RdW == 5'(i));
         dec_f = FlushE && last_valid && (last_rd == 5'(i));
         sum   = {2'b00, cnt[i]} + SW'(inc) - SW'(dec_w) - SW'(dec_f);
         if (sum[SW-1]) begin
            cnt_next[i]  = '0;
            underflow[i] = 1'b1;
         end else begin
            cnt_next[i]  = sum[CNT_W-1:0];
         end
         busy_next[i] = (cnt_next[i] != '0);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         // NOTE: the counters are a flop array, not a RAM, so clearing them all in reset is cheap and required.
         for (int i = 0; i < NREG; i++) cnt[i] <= '0;
         BusyMask   <= '0;
         last_valid <= 1'b0;
         last_rd    <= 5'd0;
         SbErr      <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) cnt[i] <= cnt_next[i];
         BusyMask   <= busy_next;
         last_valid <= tracked_issue;
         last_rd    <= RdD;
         if (|underflow) SbErr <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (NREG=32, CNT_W=2, BYPASS_W=1).
module tb_reg_scoreboard;

   logic        CLK;
   logic        RST_N;
   logic        IssueValidD;
   logic        FlushD;
   logic [4:0]  Rs1D;
   logic [4:0]  Rs2D;
   logic [4:0]  RdD;
   logic        Rs1UsedD;
   logic        Rs2UsedD;
   logic        RegWriteD;
   logic        FlushE;
   logic        RetireValidW;
   logic [4:0]  RdW;
   logic        StallD;
   logic        IssueD;
   logic [31:0] BusyMask;
   logic        SbErr;

   int n_cmp  = 0;
   int n_fail = 0;

   reg_scoreboard #(.NREG(32), .CNT_W(2), .BYPASS_W(1)) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .IssueValidD  (IssueValidD),
      .FlushD       (FlushD),
      .Rs1D         (Rs1D),
      .Rs2D         (Rs2D),
      .RdD          (RdD),
      .Rs1UsedD     (Rs1UsedD),
      .Rs2UsedD     (Rs2UsedD),
      .RegWriteD    (RegWriteD),
      .FlushE       (FlushE),
      .RetireValidW (RetireValidW),
      .RdW          (RdW),
      .StallD       (StallD),
      .IssueD       (IssueD),
      .BusyMask     (BusyMask),
      .SbErr        (SbErr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      IssueValidD  = 1'b0;
      FlushD       = 1'b0;
      Rs1D         = 5'd0;
      Rs2D         = 5'd0;
      RdD          = 5'd0;
      Rs1UsedD     = 1'b0;
      Rs2UsedD     = 1'b0;
      RegWriteD    = 1'b0;
      FlushE       = 1'b0;
      RetireValidW = 1'b0;
      RdW          = 5'd0;
   endtask

   // Advance past the next rising edge; inputs are then changed and settled before checking.
   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue_write(input logic [4:0] rd);
      idle();
      IssueValidD = 1'b1;
      RegWriteD   = 1'b1;
      RdD         = rd;
   endtask

   initial begin
      // Reset with a valid instruction presented: outputs must stay forced low.
      idle();
      RST_N = 1'b0;
      IssueValidD = 1'b1; Rs1UsedD = 1'b1; Rs1D = 5'd3; RegWriteD = 1'b1; RdD = 5'd4;
      #2;
      check("rst_issue_forced", IssueD, 0);
      check("rst_stall_forced", StallD, 0);
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      idle();
      #1;
      check("idle_busy", BusyMask, 0);
      check("idle_stall", StallD, 0);
      check("idle_issue", IssueD, 0);
      check("idle_err", SbErr, 0);

      // RAW stall on x5 with write-through bypass in the retire cycle.
      next_cycle(); issue_write(5'd5); #1;
      check("raw_producer_issue", IssueD, 1);
      next_cycle(); idle(); IssueValidD = 1'b1; Rs1UsedD = 1'b1; Rs1D = 5'd5; #1;
      check("raw_busy5", BusyMask, 32'h0000_0020);
      check("raw_stall_c1", StallD, 1);
      check("raw_noissue_c1", IssueD, 0);
      next_cycle(); #1;
      check("raw_stall_c2", StallD, 1);
      next_cycle(); RetireValidW = 1'b1; RdW = 5'd5; #1;
      check("raw_bypass_stall", StallD, 0);
      check("raw_bypass_issue", IssueD, 1);
      next_cycle(); idle(); #1;
      check("raw_busy_clear", BusyMask, 0);

      // FlushD kills decode without stalling.
      idle(); IssueValidD = 1'b1; FlushD = 1'b1; #1;
      check("flushd_issue", IssueD, 0);
      check("flushd_stall", StallD, 0);

      // x0 is never tracked.
      for (int k = 0; k < 10; k++) begin
         next_cycle(); issue_write(5'd0); #1;
         check("x0_issue", IssueD, 1);
      end
      next_cycle(); idle();
      IssueValidD = 1'b1; Rs1UsedD = 1'b1; Rs1D = 5'd0;
      RetireValidW = 1'b1; RdW = 5'd0; #1;
      check("x0_read_issue", IssueD, 1);
      check("x0_read_stall", StallD, 0);
      check("x0_busy", BusyMask, 0);
      next_cycle(); idle(); #1;
      check("x0_busy_after", BusyMask, 0);
      check("x0_err", SbErr, 0);

      // Saturation of x7 at 3 pending writes.
      for (int k = 0; k < 3; k++) begin
         next_cycle(); issue_write(5'd7); #1;
         check("sat_issue", IssueD, 1);
      end
      next_cycle(); issue_write(5'd7); #1;
      check("sat_busy7", BusyMask, 32'h0000_0080);
      check("sat_fourth_stall", StallD, 1);
      check("sat_fourth_noissue", IssueD, 0);
      IssueValidD = 1'b0; #1;
      check("sat_novalid_stall", StallD, 0);
      IssueValidD = 1'b1; #1;
      next_cycle(); #1;
      check("sat_hold_stall", StallD, 1);
      RetireValidW = 1'b1; RdW = 5'd7; #1;
      check("sat_retire_cycle_stall", StallD, 1);
      next_cycle(); RetireValidW = 1'b0; #1;
      check("sat_after_retire_issue", IssueD, 1);
      next_cycle(); idle(); RetireValidW = 1'b1; RdW = 5'd7;
      next_cycle(); #1;
      next_cycle(); #1;
      check("sat_busy_after2", BusyMask, 32'h0000_0080);
      next_cycle(); idle(); #1;
      check("sat_busy_after3", BusyMask, 0);
      check("sat_err", SbErr, 0);

      // Flush plus retire on x9 in the same cycle removes two pending writes.
      next_cycle(); issue_write(5'd9); #1;
      check("fr_first_issue", IssueD, 1);
      next_cycle(); idle(); #1;
      next_cycle(); issue_write(5'd9); #1;
      check("fr_second_issue", IssueD, 1);
      next_cycle(); idle();
      IssueValidD = 1'b1; FlushE = 1'b1; RetireValidW = 1'b1; RdW = 5'd9; #1;
      check("fr_busy9", BusyMask, 32'h0000_0200);
      check("fr_flushe_no_block", IssueD, 1);
      next_cycle(); idle(); #1;
      check("fr_busy_clear", BusyMask, 0);
      check("fr_err", SbErr, 0);

      // Underflow on x12 sets the sticky error.
      next_cycle(); idle(); RetireValidW = 1'b1; RdW = 5'd12; #1;
      check("uf_err_before", SbErr, 0);
      next_cycle(); idle(); #1;
      check("uf_err_set", SbErr, 1);
      check("uf_busy", BusyMask, 0);
      next_cycle(); issue_write(5'd3); #1;
      check("uf_issue_x3", IssueD, 1);
      next_cycle(); idle(); #1;
      check("uf_err_sticky", SbErr, 1);
      check("uf_busy3", BusyMask, 32'h0000_0008);

      // Mid-operation reset discards pending x3 without flagging an error.
      RST_N = 1'b0; IssueValidD = 1'b1; Rs1UsedD = 1'b1; Rs1D = 5'd3; #1;
      check("mid_rst_issue", IssueD, 0);
      check("mid_rst_stall", StallD, 0);
      next_cycle(); RST_N = 1'b1; idle(); #1;
      check("post_rst_err", SbErr, 0);
      check("post_rst_busy", BusyMask, 0);
      IssueValidD = 1'b1; Rs1UsedD = 1'b1; Rs1D = 5'd3; #1;
      check("post_rst_read_x3", IssueD, 1);
      next_cycle(); idle(); #1;
      check("post_rst_err_final", SbErr, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
